instr_mem_controller: RTL and testbench
=======================================

INSTR_MEM_CONTROLLER -- requirements
Module: instr_mem_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction word width.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port io_loadValid  in  1  loader word valid.
REQ-006 SHALL have port io_loadData  in  INSTR_W  loader instruction word.
REQ-007 SHALL have port io_loadLast  in  1  marks final word of program.
REQ-008 SHALL have port io_loadReady  out  1  controller accepts loader word.
REQ-009 SHALL have port io_restart  in  1  return to LOAD, discarding the current program.
REQ-010 SHALL have port io_fetchReq  in  1  CPU fetch request.
REQ-011 SHALL have port io_fetchAddr  in  ADDR_W  CPU fetch address.
REQ-012 SHALL have port io_fetchValid  out  1  fetch response valid.
REQ-013 SHALL have port io_fetchInstr  out  INSTR_W  fetched instruction.
REQ-014 SHALL have port io_cpuRun  out  1  CPU enable.
REQ-015 SHALL have port io_fault  out  1  program overran memory.
REQ-016 SHALL have port io_loadCount  out  ADDR_W+1  words accepted, 0..2^ADDR_W.
REQ-017 SHALL have ports io_memAddr (out, ADDR_W), io_memInstrIn (out, INSTR_W), io_memInstrWrite (out, 1), io_memInstrOut (in, INSTR_W) driving the instruction memory; memory read is combinational, write occurs at the clock edge.

Function
REQ-018 SHALL implement states LOAD, RUN, FAULT; the state after reset SHALL be LOAD.
REQ-019 SHALL drive io_loadReady = (state==LOAD) AND NOT io_restart; a handshake occurs when io_loadValid AND io_loadReady.
REQ-020 On handshake, SHALL assert io_memInstrWrite, drive io_memAddr = wptr and io_memInstrIn = io_loadData in the same cycle, then increment wptr and io_loadCount.
REQ-021 On handshake with io_loadLast=1, SHALL move to RUN on the next cycle.
REQ-022 On handshake at wptr = 2^ADDR_W-1 with io_loadLast=0, SHALL write the word, set io_loadCount = 2^ADDR_W, and move to FAULT; wptr SHALL NOT wrap into a further write.
REQ-023 In RUN, SHALL drive io_memAddr = io_fetchAddr and io_memInstrWrite = 0; io_loadValid SHALL be ignored.
REQ-024 In RUN, io_fetchReq in cycle N SHALL produce io_fetchValid=1 and io_fetchInstr = memory[io_fetchAddr] in cycle N+1 (registered, 1-cycle latency); back-to-back requests SHALL be supported at 1 per cycle.
REQ-025 io_fetchReq in LOAD or FAULT SHALL be ignored; io_fetchValid SHALL remain 0.
REQ-026 io_cpuRun SHALL equal (state==RUN); io_fault SHALL equal (state==FAULT).
REQ-027 In LOAD or FAULT, io_memAddr SHALL be wptr (LOAD) or 0 (FAULT), with io_memInstrWrite = 0 unless REQ-020 applies.
REQ-028 io_restart in any state SHALL move to LOAD next cycle, clear wptr and io_loadCount, and clear io_fetchValid next cycle; a loader word presented in the same cycle SHALL NOT be written (REQ-019).
REQ-029 io_restart SHALL take priority over io_loadLast and over a fetch issued in the same cycle.

Reset
REQ-030 Reset SHALL force state=LOAD, wptr=0, io_loadCount=0, io_fetchValid=0, io_fetchInstr=0, io_cpuRun=0, io_fault=0.
REQ-031 Reset asserted mid-load or mid-run SHALL abandon the operation with identical results; memory contents SHALL NOT be cleared.

Structure
REQ-032 The state enumeration, ADDR_W and INSTR_W defaults SHALL reside in a shared package used by the controller and the instruction memory.
REQ-033 The block SHALL be a single module with no sub-modules; it SHALL instantiate no memory, only drive the existing instruction memory's ports.

Verification
REQ-034 Load 0x1234, 0xABCD (last) -> writes at addresses 0,1; io_loadCount=2; io_cpuRun=1 on the cycle after the last handshake.
REQ-035 RUN, io_fetchReq with io_fetchAddr 1 then 0 on consecutive cycles -> io_fetchValid=1 with 0xABCD, then 0x1234, one cycle later each.
REQ-036 Load 256 words without last -> io_fault=1, io_loadCount=256, io_loadReady=0, io_cpuRun=0; io_fetchReq yields no io_fetchValid.
REQ-037 io_restart with io_loadValid=1 during LOAD at wptr=5 -> io_loadReady=0, no write; next cycle io_loadCount=0, first new word written at address 0.
REQ-038 Reset asserted in RUN while io_fetchReq=1 -> next cycle io_fetchValid=0, state LOAD, io_cpuRun=0; previously written memory words are readable after reload with io_loadLast on first word.

Source files
------------

// File: rtl/instr_mem_controller_pkg.sv
// rtl/instr_mem_controller_pkg.sv - shared state encoding and width defaults for the instruction memory path
package instr_mem_controller_pkg;

  localparam int ADDR_W_DEFAULT  = 8;
  localparam int INSTR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem_controller.sv
// rtl/instr_mem_controller.sv - loads a program into instruction memory, then serves CPU fetches
module instr_mem_controller
  import instr_mem_controller_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_loadValid,
  input  logic [INSTR_W-1:0] io_loadData,
  input  logic               io_loadLast,
  output logic               io_loadReady,
  input  logic               io_restart,
  input  logic               io_fetchReq,
  input  logic [ADDR_W-1:0]  io_fetchAddr,
  output logic               io_fetchValid,
  output logic [INSTR_W-1:0] io_fetchInstr,
  output logic               io_cpuRun,
  output logic               io_fault,
  output logic [ADDR_W:0]    io_loadCount,
  output logic [ADDR_W-1:0]  io_memAddr,
  output logic [INSTR_W-1:0] io_memInstrIn,
  output logic               io_memInstrWrite,
  input  logic [INSTR_W-1:0] io_memInstrOut
);

  localparam logic [ADDR_W-1:0] WPTR_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic              handshake;

  assign io_loadReady     = (state == ST_LOAD) && !io_restart;
  // Writes are suppressed while reset is held so an abandoned load leaves memory untouched.
  assign handshake        = io_loadValid && io_loadReady && !reset;
  assign io_memInstrWrite = handshake;
  assign io_memInstrIn    = io_loadData;
  assign io_cpuRun        = (state == ST_RUN);
  assign io_fault         = (state == ST_FAULT);

  always_comb begin
    io_memAddr = '0;
    case (state)
      ST_LOAD: io_memAddr = wptr;
      ST_RUN:  io_memAddr = io_fetchAddr;
      default: io_memAddr = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_LOAD;
      wptr          <= '0;
      io_loadCount  <= '0;
      io_fetchValid <= 1'b0;
      io_fetchInstr <= '0;
    end else if (io_restart) begin
      state         <= ST_LOAD;
      wptr          <= '0;
      io_loadCount  <= '0;
      io_fetchValid <= 1'b0;
    end else begin
      io_fetchValid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (handshake) begin
            wptr         <= wptr + ADDR_W'(1);
            io_loadCount <= io_loadCount + (ADDR_W+1)'(1);
            // Last word wins even at the top address: a full-size program is legal.
            if (io_loadLast)
              state <= ST_RUN;
            else if (wptr == WPTR_LAST)
              state <= ST_FAULT;
          end
        end
        ST_RUN: begin
          if (io_fetchReq) begin
            io_fetchValid <= 1'b1;
            io_fetchInstr <= io_memInstrOut;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_controller.sv
// tb/tb_instr_mem_controller.sv - randomized and directed check of instr_mem_controller against a program-level model
module tb_instr_mem_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_loadValid, io_loadLast, io_loadReady, io_restart;
  logic [15:0] io_loadData;
  logic        io_fetchReq, io_fetchValid, io_cpuRun, io_fault;
  logic [7:0]  io_fetchAddr, io_memAddr;
  logic [15:0] io_fetchInstr, io_memInstrIn, io_memInstrOut;
  logic [8:0]  io_loadCount;
  logic        io_memInstrWrite;

  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected behaviour: mode 0 = loading, 1 = running, 2 = overran.
  int          m_mode;
  int          m_cnt;
  bit          m_fv;
  logic [15:0] m_fi;
  logic [15:0] ref_mem [0:255];

  instr_mem_controller dut (
    .clock(clock), .reset(reset),
    .io_loadValid(io_loadValid), .io_loadData(io_loadData), .io_loadLast(io_loadLast),
    .io_loadReady(io_loadReady), .io_restart(io_restart),
    .io_fetchReq(io_fetchReq), .io_fetchAddr(io_fetchAddr),
    .io_fetchValid(io_fetchValid), .io_fetchInstr(io_fetchInstr),
    .io_cpuRun(io_cpuRun), .io_fault(io_fault), .io_loadCount(io_loadCount),
    .io_memAddr(io_memAddr), .io_memInstrIn(io_memInstrIn),
    .io_memInstrWrite(io_memInstrWrite), .io_memInstrOut(io_memInstrOut)
  );

  always #5 clock = ~clock;

  assign io_memInstrOut = mem[io_memAddr];
  always @(posedge clock) if (io_memInstrWrite) mem[io_memAddr] <= io_memInstrIn;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic step(input bit rst, input bit r, input bit v, input bit l, input bit fr,
                      input logic [15:0] d, input logic [7:0] fa);
    bit         hs;
    logic [7:0] exp_addr;
    reset = rst; io_restart = r; io_loadValid = v; io_loadLast = l;
    io_fetchReq = fr; io_loadData = d; io_fetchAddr = fa;
    #1;
    hs = v && (m_mode == 0) && !r && !rst;
    exp_addr = (m_mode == 1) ? fa : (m_mode == 0) ? m_cnt[7:0] : 8'd0;
    check_value("load_ready", io_loadReady, (m_mode == 0) && !r);
    check_value("mem_write", io_memInstrWrite, hs);
    check_value("mem_addr", io_memAddr, exp_addr);
    if (hs) check_value("mem_wdata", io_memInstrIn, d);
    check_value("cpu_run", io_cpuRun, m_mode == 1);
    check_value("fault", io_fault, m_mode == 2);
    check_value("load_count", io_loadCount, m_cnt);
    check_value("fetch_valid", io_fetchValid, m_fv);
    if (m_fv) check_value("fetch_instr", io_fetchInstr, m_fi);

    if (rst || r) begin
      m_mode = 0; m_cnt = 0; m_fv = 0;
      if (rst) m_fi = '0;
    end else begin
      m_fv = 0;
      if (m_mode == 0 && hs) begin
        ref_mem[m_cnt] = d;
        m_cnt++;
        if (l) m_mode = 1;
        else if (m_cnt == 256) m_mode = 2;
      end else if (m_mode == 1 && fr) begin
        m_fv = 1;
        m_fi = ref_mem[fa];
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    bit rst, r, v, l, fr;
    int last_div, rst_div, rs_div;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_mode = 0; m_cnt = 0; m_fv = 0; m_fi = '0;
    reset = 1; io_restart = 0; io_loadValid = 0; io_loadLast = 0;
    io_fetchReq = 0; io_loadData = '0; io_fetchAddr = '0;
    @(negedge clock); @(negedge clock);
    step(1, 0, 0, 0, 0, 16'h0, 8'h0);
    check_value("reset_fetch_instr", io_fetchInstr, 16'h0);

    step(0, 0, 1, 0, 0, 16'h1234, 8'h0);
    step(0, 0, 1, 1, 0, 16'hABCD, 8'h0);
    check_value("prog2_run", io_cpuRun, 1'b1);
    check_value("prog2_count", io_loadCount, 9'd2);
    check_value("prog2_mem1", mem[1], 16'hABCD);

    step(0, 0, 1, 0, 1, 16'h5555, 8'd1);
    check_value("fetch_a1", io_fetchInstr, 16'hABCD);
    step(0, 0, 0, 0, 1, 16'h0, 8'd0);
    check_value("fetch_a0", io_fetchInstr, 16'h1234);
    step(0, 0, 0, 0, 0, 16'h0, 8'd0);

    step(1, 0, 0, 0, 1, 16'h0, 8'd1);
    step(0, 0, 1, 1, 0, 16'h7777, 8'd0);
    step(0, 0, 0, 0, 1, 16'h0, 8'd1);
    check_value("after_reset_mem1", io_fetchInstr, 16'hABCD);
    step(0, 0, 0, 0, 0, 16'h0, 8'd0);

    step(0, 1, 0, 0, 0, 16'h0, 8'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 16'h4000 + 16'(i), 8'd0);
    check_value("restart_wptr5", io_loadCount, 9'd5);
    step(0, 1, 1, 0, 0, 16'hDEAD, 8'd0);
    check_value("restart_no_write", mem[5], 16'h0);
    step(0, 0, 1, 0, 0, 16'hBEEF, 8'd0);
    check_value("restart_first_at0", mem[0], 16'hBEEF);

    step(0, 1, 0, 0, 0, 16'h0, 8'd0);
    for (int i = 0; i < 256; i++) step(0, 0, 1, 0, 0, 16'($urandom), 8'd0);
    check_value("overrun_fault", io_fault, 1'b1);
    check_value("overrun_count", io_loadCount, 9'd256);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 16'h1, 8'(i));
    check_value("overrun_no_fetch", io_fetchValid, 1'b0);

    for (int i = 0; i < 6000; i++) begin
      last_div = (i < 3000) ? 30 : 700;
      rs_div   = (i < 3000) ? 100 : 900;
      rst_div  = (i < 3000) ? 250 : 1500;
      rst = ($urandom_range(0, rst_div - 1) == 0);
      r   = ($urandom_range(0, rs_div - 1) == 0);
      v   = ($urandom_range(0, 9) < 7);
      l   = ($urandom_range(0, last_div - 1) == 0);
      fr  = ($urandom_range(0, 9) < 6);
      step(rst, r, v, l, fr, 16'($urandom), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
